overlap_column_merger: RTL and testbench
========================================

// Module: overlap_column_merger
// PURPOSE
// - Downstream consumer of core_overlap_prsc. Accepts its overlapped columns (valid pulse, no backpressure upstream).
// - Overlap-adds the leading pixels of each column into the trailing pixels held from the previous column.
// - Streams finalized pixels out over a valid/ready handshake; drains the held tail on a last-column marker.
// - Sits between the overlap processor and the output row writer of the transposed-conv datapath.
// PARAMETERS
// - SIZE_OF_EACH_CORE_INPUT  2  per-core input tile size
// - SIZE_OF_EACH_KERNEL      3  kernel size
// - STRIDE                   1  stride
// - PIX_WIDTH                8  bits per unsigned pixel
// - SIZE_OF_PRSC_OUTPUT      STRIDE*(SIZE_OF_EACH_CORE_INPUT-1)+SIZE_OF_EACH_KERNEL+SIZE_OF_EACH_CORE_INPUT*STRIDE (6)  pixels per input column
// - OVERLAP                  SIZE_OF_EACH_KERNEL-STRIDE (2)  pixels shared by consecutive columns
// - EMIT                     SIZE_OF_PRSC_OUTPUT-OVERLAP (4)  pixels finalized per column
// PORTS
// - clk_i            in   1                            clock, all logic on rising edge
// - rst_i            in   1                            synchronous, active-high reset
// - en_i             in   1                            block enable; low = no new accepts, no flush start
// - valid_i          in   1                            column_i valid (from core_overlap_prsc valid_o)
// - last_i           in   1                            qualifies column_i as last column of the row
// - column_i         in   PIX_WIDTH*SIZE_OF_PRSC_OUTPUT overlapped column, pixel 0 at LSBs
// - ready_o          out  1                            merger can accept column_i this cycle
// - valid_o          out  1                            merged_o holds a result
// - ready_i          in   1                            downstream accepts merged_o
// - merged_o         out  PIX_WIDTH*EMIT               finalized pixels, pixel 0 at LSBs
// - flush_o          out  1                            merged_o is a tail drain (OVERLAP valid pixels, upper pixels 0)
// BEHAVIOUR
// - Reset: valid_o=0, flush_o=0, merged_o=0, tail=0, state=IDLE; ready_o=0 during reset cycle. Reset mid-row discards tail and held output.
// - Accept = valid_i & ready_o. ready_o = en_i & (state!=FLUSH) & (!valid_o | ready_i).
// - valid_i while ready_o=0: column is dropped and err_drop sticky bit (internal, visible in sim) is set; upstream must not do this.
// - On accept: pixel k (k<OVERLAP) = column_i[k] + tail[k]; pixels OVERLAP..EMIT-1 pass through; result registered to merged_o, valid_o=1 next cycle (latency 1).
// - New tail = column_i pixels EMIT..SIZE_OF_PRSC_OUTPUT-1.
// - In IDLE the tail is treated as 0.
// - Output register holds until valid_o & ready_i; accept and drain in the same cycle are legal (full throughput).
// - FSM IDLE: accept & !last_i -> ACCUM; accept & last_i -> FLUSH.
// - FSM ACCUM: accept & !last_i -> ACCUM; accept & last_i -> FLUSH.
// - FSM FLUSH: when en_i & (!valid_o | ready_i), load merged_o = {0.., tail}, flush_o=1, valid_o=1, tail=0 -> IDLE.
// - flush_o clears when a non-flush result loads, or on drain with no new load.
// - en_i low: held output still drains; FSM and tail are frozen.
// CONFIGURATION
// - OVERLAP_SATURATE_EN defined: per-pixel unsigned add saturates at 2^PIX_WIDTH-1.
// - OVERLAP_SATURATE_EN undefined: add wraps modulo 2^PIX_WIDTH.
// STRUCTURE
// - Package overlap_pkg: derived localparams SIZE_OF_PRSC_INPUT, SIZE_OF_PRSC_OUTPUT, OVERLAP, EMIT, NON_OVERLAPPED_CONST; FSM state encoding (IDLE/ACCUM/FLUSH). Shared with core_overlap_prsc.
// - Sub-module pix_overlap_add: one PIX_WIDTH adder, saturation selected by OVERLAP_SATURATE_EN; instantiated OVERLAP times in a generate loop.
// TESTING
// - Reset then col {06,05,04,03,02,01}, ready_i=1 -> next cycle valid_o=1, merged_o=32'h04030201; tail={06,05}.
// - Follow with col all 8'h10 -> merged_o=32'h10101615, flush_o=0.
// - Col with last_i=1 -> FSM in FLUSH, ready_o=0; next result flush_o=1, merged_o=32'h0000_{tail}; FSM returns to IDLE.
// - tail={FF,FF}, next col low pixels F0 -> merged pixels 0,1 = FF with OVERLAP_SATURATE_EN, EF without.
// - ready_i=0 for 5 cycles with valid_o=1 -> merged_o stable, ready_o=0; ready_i=1 with valid_i -> drain + accept same cycle, no gap.
// - rst_i pulsed while in ACCUM -> all outputs 0; next col emitted with tail=0 (matches first-column value).

Source files
------------

// File: rtl/overlap_column_merger_pkg.sv
// Shared geometry and FSM encoding for the overlap processor and column merger.
package overlap_pkg;
  localparam int SIZE_OF_EACH_CORE_INPUT = 2;
  localparam int SIZE_OF_EACH_KERNEL     = 3;
  localparam int STRIDE                  = 1;
  localparam int PIX_WIDTH               = 8;

  localparam int SIZE_OF_PRSC_INPUT  = SIZE_OF_EACH_CORE_INPUT;
  localparam int SIZE_OF_PRSC_OUTPUT = STRIDE*(SIZE_OF_EACH_CORE_INPUT-1) + SIZE_OF_EACH_KERNEL
                                       + SIZE_OF_EACH_CORE_INPUT*STRIDE;
  localparam int OVERLAP              = SIZE_OF_EACH_KERNEL - STRIDE;
  localparam int EMIT                 = SIZE_OF_PRSC_OUTPUT - OVERLAP;
  localparam int NON_OVERLAPPED_CONST = EMIT - OVERLAP;

  localparam int COL_W  = PIX_WIDTH*SIZE_OF_PRSC_OUTPUT;
  localparam int OUT_W  = PIX_WIDTH*EMIT;
  localparam int TAIL_W = PIX_WIDTH*OVERLAP;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;
endpackage

// File: rtl/overlap_column_merger_pix_add.sv
// Single-pixel overlap adder; saturates when OVERLAP_SATURATE_EN is defined, wraps otherwise.
module pix_overlap_add
  import overlap_pkg::*;
(
  input  logic [PIX_WIDTH-1:0] a_i,
  input  logic [PIX_WIDTH-1:0] b_i,
  output logic [PIX_WIDTH-1:0] sum_o
);
`ifdef OVERLAP_SATURATE_EN
  logic [PIX_WIDTH:0] wide;
  assign wide  = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o = wide[PIX_WIDTH] ? {PIX_WIDTH{1'b1}} : wide[PIX_WIDTH-1:0];
`else
  assign sum_o = a_i + b_i;
`endif
endmodule

// File: rtl/overlap_column_merger.sv
// Overlap-adds consecutive prsc columns and streams finalized pixels; drains the tail on last column.
// Build option: OVERLAP_SATURATE_EN selects saturating instead of wrapping pixel adds.
module overlap_column_merger
  import overlap_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic             last_i,
  input  logic [COL_W-1:0] column_i,
  output logic             ready_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [OUT_W-1:0] merged_o,
  output logic             flush_o
);
  state_e state_q, state_d;
  logic valid_q, valid_d, flush_q, flush_d, err_drop_q, err_drop_d;
  logic [OUT_W-1:0] merged_q, merged_d;
  logic [TAIL_W-1:0] tail_q, tail_d, tail_eff, sum;
  logic out_free, accept, drain, flush_load;

  assign out_free   = !valid_q | ready_i;
  assign ready_o    = !rst_i & en_i & (state_q != ST_FLUSH) & out_free;
  assign accept     = valid_i & ready_o;
  assign drain      = valid_q & ready_i;
  assign flush_load = !rst_i & en_i & (state_q == ST_FLUSH) & out_free;
  assign tail_eff   = (state_q == ST_IDLE) ? '0 : tail_q;

  for (genvar k = 0; k < OVERLAP; k++) begin : g_add
    pix_overlap_add u_add (
      .a_i  (column_i[k*PIX_WIDTH +: PIX_WIDTH]),
      .b_i  (tail_eff[k*PIX_WIDTH +: PIX_WIDTH]),
      .sum_o(sum[k*PIX_WIDTH +: PIX_WIDTH])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ACCUM: if (accept) state_d = last_i ? ST_FLUSH : ST_ACCUM;
      ST_FLUSH:          if (flush_load) state_d = ST_IDLE;
      default:           state_d = ST_IDLE;
    endcase
  end

  // Accept and flush are mutually exclusive: ready_o is low in FLUSH.
  always_comb begin
    valid_d    = valid_q;
    flush_d    = flush_q;
    merged_d   = merged_q;
    tail_d     = tail_q;
    err_drop_d = err_drop_q | (valid_i & !ready_o);
    if (drain) begin
      valid_d = 1'b0;
      flush_d = 1'b0;
    end
    if (accept) begin
      merged_d = {column_i[EMIT*PIX_WIDTH-1:TAIL_W], sum};
      tail_d   = column_i[COL_W-1:EMIT*PIX_WIDTH];
      valid_d  = 1'b1;
      flush_d  = 1'b0;
    end else if (flush_load) begin
      merged_d = OUT_W'(tail_q);
      tail_d   = '0;
      valid_d  = 1'b1;
      flush_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      merged_q   <= '0;
      tail_q     <= '0;
      err_drop_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      flush_q    <= flush_d;
      merged_q   <= merged_d;
      tail_q     <= tail_d;
      err_drop_q <= err_drop_d;
    end
  end

  assign valid_o  = valid_q;
  assign flush_o  = flush_q;
  assign merged_o = merged_q;
endmodule

// File: tb/tb_overlap_column_merger.sv
// Directed scoreboard bench for overlap_column_merger.
module tb_overlap_column_merger;
  import overlap_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_i, en_i, valid_i, last_i, ready_i;
  logic [COL_W-1:0] column_i;
  logic             ready_o, valid_o, flush_o;
  logic [OUT_W-1:0] merged_o;

  overlap_column_merger dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .valid_i(valid_i), .last_i(last_i),
    .column_i(column_i), .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i),
    .merged_o(merged_o), .flush_o(flush_o)
  );

  int checks   = 0;
  int failures = 0;

  logic [OUT_W:0]     sb_q[$];
  state_e             m_state;
  logic [PIX_WIDTH-1:0] m_tail[OVERLAP];
  logic               m_valid;

  function automatic logic [PIX_WIDTH-1:0] add_px(input logic [PIX_WIDTH-1:0] a, b);
    logic [PIX_WIDTH:0] w;
    w = {1'b0, a} + {1'b0, b};
`ifdef OVERLAP_SATURATE_EN
    return w[PIX_WIDTH] ? {PIX_WIDTH{1'b1}} : w[PIX_WIDTH-1:0];
`else
    return w[PIX_WIDTH-1:0];
`endif
  endfunction

  task automatic check(input string tag, input logic [OUT_W:0] obs, input logic [OUT_W:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle (called just after a negedge), check, update the model, advance to next negedge.
  task automatic cycle(input logic rst, en, v, last, rdy, input logic [COL_W-1:0] col);
    logic exp_ready, acc, fl;
    logic [OUT_W:0] exp;
    rst_i = rst; en_i = en; valid_i = v; last_i = last; ready_i = rdy; column_i = col;
    #1;
    exp_ready = !rst & en & (m_state != ST_FLUSH) & (!m_valid | rdy);
    check("ready_o", {{OUT_W{1'b0}}, ready_o}, {{OUT_W{1'b0}}, exp_ready});
    check("valid_o", {{OUT_W{1'b0}}, valid_o}, {{OUT_W{1'b0}}, m_valid});
    if (m_valid) check("merged", {flush_o, merged_o}, sb_q[0]);
    if (rst) begin
      sb_q.delete();
      m_valid = 1'b0;
      m_state = ST_IDLE;
      for (int k = 0; k < OVERLAP; k++) m_tail[k] = '0;
    end else begin
      acc = v & exp_ready;
      fl  = en & (m_state == ST_FLUSH) & (!m_valid | rdy);
      if (m_valid & rdy) void'(sb_q.pop_front());
      if (acc) begin
        exp = '0;
        for (int k = 0; k < OVERLAP; k++)
          exp[k*PIX_WIDTH +: PIX_WIDTH] = add_px(col[k*PIX_WIDTH +: PIX_WIDTH],
                                                 (m_state == ST_IDLE) ? '0 : m_tail[k]);
        for (int k = OVERLAP; k < EMIT; k++)
          exp[k*PIX_WIDTH +: PIX_WIDTH] = col[k*PIX_WIDTH +: PIX_WIDTH];
        sb_q.push_back(exp);
        for (int k = 0; k < OVERLAP; k++) m_tail[k] = col[(EMIT+k)*PIX_WIDTH +: PIX_WIDTH];
        m_state = last ? ST_FLUSH : ST_ACCUM;
      end else if (fl) begin
        exp = '0;
        exp[OUT_W] = 1'b1;
        for (int k = 0; k < OVERLAP; k++) begin
          exp[k*PIX_WIDTH +: PIX_WIDTH] = m_tail[k];
          m_tail[k] = '0;
        end
        sb_q.push_back(exp);
        m_state = ST_IDLE;
      end
      m_valid = acc | fl | (m_valid & !rdy);
    end
    @(negedge clk);
  endtask

  initial begin
    m_state = ST_IDLE;
    m_valid = 1'b0;
    for (int k = 0; k < OVERLAP; k++) m_tail[k] = '0;
    rst_i = 1'b1; en_i = 1'b0; valid_i = 1'b0; last_i = 1'b0; ready_i = 1'b0; column_i = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_merged", {1'b0, merged_o}, '0);
    check("rst_flush",  {{OUT_W{1'b0}}, flush_o}, '0);
    cycle(1, 1, 1, 0, 1, 48'h060504030201);

    // Basic overlap-add sequence ending with a last column and tail flush
    cycle(0, 1, 1, 0, 1, 48'h060504030201);
    cycle(0, 1, 1, 0, 1, {6{8'h10}});
    cycle(0, 1, 1, 1, 1, 48'h363534333231);
    cycle(0, 1, 0, 0, 1, '0);
    cycle(0, 1, 0, 0, 1, '0);

    // Tail FF,FF overlapping F0 pixels
    cycle(0, 1, 1, 0, 1, 48'hFFFF44332211);
    cycle(0, 1, 1, 0, 1, 48'h00000000F0F0);

    // Output stall for 5 cycles, then drain and accept together
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, '0);
    cycle(0, 1, 1, 0, 1, 48'h0C0B0A090807);

    // Enable low: held output drains, no accept, tail frozen
    cycle(0, 0, 0, 0, 1, '0);
    cycle(0, 0, 0, 0, 1, '0);
    cycle(0, 1, 1, 0, 1, 48'h050403020101);

    // Reset in the middle of a row
    cycle(1, 1, 0, 0, 0, '0);
    check("midrst_merged", {1'b0, merged_o}, '0);
    check("midrst_flush",  {{OUT_W{1'b0}}, flush_o}, '0);
    cycle(0, 1, 1, 0, 1, 48'h060504030201);
    cycle(0, 1, 0, 0, 1, '0);
    cycle(0, 1, 0, 0, 1, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
